// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out unloader.
// State encodings are shared with the SIPO/PISO control wrapper.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/piso.sv
// Parallel-in serial-out unloader: captures a wide vector in one cycle
// and streams it LSW first over valid/ready with address and last flag.
module piso
  import piso_pkg::*;
#(
  parameter int R_DATA_WIDTH = 32,
  parameter int N_REG        = 8,
  parameter int N_REG_BITS   = (N_REG > 1) ? $clog2(N_REG) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          clr,
  input  logic [R_DATA_WIDTH*N_REG-1:0] din,
  output logic [R_DATA_WIDTH-1:0]       dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [N_REG_BITS-1:0]         dout_addr,
  output logic                          dout_last,
  output logic                          busy,
  output logic                          done
);

  localparam logic [N_REG_BITS-1:0] CNT_LAST =
    N_REG_BITS'(N_REG - 1);

  state_t                                 state;
  logic [N_REG_BITS-1:0]                  cnt;
  logic [N_REG-1:0][R_DATA_WIDTH-1:0]     shadow;
  logic                                   at_last;

  assign at_last = (cnt == CNT_LAST);

  // Sequencer: walks cnt through the words, one step per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SEND;
            cnt   <= '0;
          end
        end
        SEND: begin
          if (dout_ready) begin
            if (at_last) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Shadow bank: loaded only on an accepted start so a stream never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (state == IDLE && start && !clr) begin
      shadow <= din;
    end
  end

  // All outputs decode registers only; nothing passes through from
  // din or dout_ready.
  assign dout       = shadow[cnt];
  assign dout_addr  = cnt;
  assign dout_valid = (state == SEND);
  assign dout_last  = (state == SEND) && at_last;
  assign busy       = (state == SEND) || (state == DONE);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_piso.sv
// Self-checking bench for piso: an 8-word build driven against a
// queue-based transaction model, plus a single-word build.
module tb_piso;

  logic         clk;
  logic         rst;
  logic         start;
  logic         clr;
  logic [255:0] din;
  logic [31:0]  dout;
  logic         dout_valid;
  logic         dout_ready;
  logic [2:0]   dout_addr;
  logic         dout_last;
  logic         busy;
  logic         done;

  logic         start1;
  logic         clr1;
  logic [31:0]  din1;
  logic [31:0]  dout1;
  logic         dout_valid1;
  logic         dout_ready1;
  logic [0:0]   dout_addr1;
  logic         dout_last1;
  logic         busy1;
  logic         done1;

  int checks;
  int failures;

  typedef struct {
    logic [2:0]  a;
    logic [31:0] d;
  } beat_t;

  beat_t pend[$];
  bit    done_exp;

  piso #(.R_DATA_WIDTH(32), .N_REG(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .clr        (clr),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_addr  (dout_addr),
    .dout_last  (dout_last),
    .busy       (busy),
    .done       (done)
  );

  piso #(.R_DATA_WIDTH(32), .N_REG(1)) u_one (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .clr        (clr1),
    .din        (din1),
    .dout       (dout1),
    .dout_valid (dout_valid1),
    .dout_ready (dout_ready1),
    .dout_addr  (dout_addr1),
    .dout_last  (dout_last1),
    .busy       (busy1),
    .done       (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pat_a5();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = 32'hA5A5_0000 + i;
    return v;
  endfunction

  function automatic logic [255:0] pat_rand();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // One clock: check outputs against the model, then advance the model
  // at transaction level (capture / accept / abort) and cross the edge.
  task automatic tick(input bit rdy, input bit st, input bit cl,
                      input logic [255:0] d);
    bit ev;
    dout_ready = rdy;
    start      = st;
    clr        = cl;
    din        = d;
    #1;
    ev = (pend.size() > 0);
    chk("valid", dout_valid, ev);
    chk("busy", busy, ev || done_exp);
    chk("done", done, done_exp);
    if (ev) begin
      chk("dout", dout, pend[0].d);
      chk("addr", dout_addr, pend[0].a);
      chk("last", dout_last, pend.size() == 1);
    end
    if (cl) begin
      pend.delete();
      done_exp = 0;
    end else if (done_exp) begin
      done_exp = 0;
    end else if (pend.size() == 0) begin
      if (st)
        for (int i = 0; i < 8; i++)
          pend.push_back('{a: 3'(i), d: d[32*i +: 32]});
    end else if (rdy) begin
      void'(pend.pop_front());
      if (pend.size() == 0) done_exp = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit rnd, input logic [255:0] d);
    for (int k = 0; k < 80 && (pend.size() > 0 || done_exp); k++)
      tick(rnd ? bit'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0, d);
    tick(1'b0, 1'b0, 1'b0, d);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    logic [255:0] d;
    logic [255:0] d2;
    checks     = 0;
    failures   = 0;
    done_exp   = 0;
    rst        = 1'b1;
    start      = 1'b0;
    clr        = 1'b0;
    din        = '0;
    dout_ready = 1'b0;
    start1     = 1'b0;
    clr1       = 1'b0;
    din1       = '0;
    dout_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_addr", dout_addr, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick(1'b1, 1'b0, 1'b0, '0);

    // 1: ready tied high
    d = pat_a5();
    tick(1'b1, 1'b1, 1'b0, d);
    drain(1'b0, d);

    // 2: ready 1,0,0,1 pattern with random data
    d = pat_rand();
    tick(1'b0, 1'b1, 1'b0, d);
    for (int i = 0; i < 60 && (pend.size() > 0 || done_exp); i++)
      tick((i % 4 == 0) || (i % 4 == 3), 1'b0, 1'b0, d);
    drain(1'b0, d);

    // 3: new din and start mid-stream are ignored
    d  = pat_a5();
    d2 = pat_rand();
    tick(1'b1, 1'b1, 1'b0, d);
    repeat (3) tick(1'b1, 1'b0, 1'b0, d);
    repeat (3) tick(1'b1, 1'b1, 1'b0, d2);
    drain(1'b0, d2);

    // start held through DONE is ignored until IDLE
    d = pat_rand();
    tick(1'b1, 1'b1, 1'b0, d);
    for (int i = 0; i < 20 && !done_exp; i++)
      tick(1'b1, 1'b0, 1'b0, d);
    tick(1'b1, 1'b1, 1'b0, pat_rand());
    chk("restart_gap", dout_valid, 1'b0);
    drain(1'b0, d);

    // 4: clr at addr 4, then replay
    d = pat_a5();
    tick(1'b1, 1'b1, 1'b0, d);
    for (int i = 0; i < 20 && pend.size() > 0 && pend[0].a != 3'd4; i++)
      tick(1'b1, 1'b0, 1'b0, d);
    chk("clr_at4", dout_addr, 3'd4);
    tick(1'b1, 1'b0, 1'b1, d);
    repeat (3) tick(1'b1, 1'b0, 1'b0, d);
    tick(1'b1, 1'b1, 1'b0, d);
    drain(1'b1, d);

    // clr beats start in IDLE
    tick(1'b1, 1'b1, 1'b1, pat_rand());
    repeat (2) tick(1'b1, 1'b0, 1'b0, '0);

    // random streams
    for (int n = 0; n < 4; n++) begin
      d = pat_rand();
      tick(bit'($urandom_range(0, 1)), 1'b1, 1'b0, d);
      drain(1'b1, d);
    end

    // 5: async reset between edges
    d = pat_rand();
    tick(1'b1, 1'b1, 1'b0, d);
    repeat (3) tick(1'b1, 1'b0, 1'b0, d);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_dout", dout, 0);
    chk("arst_valid", dout_valid, 0);
    chk("arst_addr", dout_addr, 0);
    chk("arst_last", dout_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    pend.delete();
    done_exp = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick(1'b1, 1'b0, 1'b0, d);
    tick(1'b1, 1'b1, 1'b0, d);
    drain(1'b0, d);

    // 6: single-word build
    din1        = 32'hDEAD_BEEF;
    start1      = 1'b1;
    dout_ready1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    chk("one_valid", dout_valid1, 1'b1);
    chk("one_dout", dout1, 32'hDEAD_BEEF);
    chk("one_addr", dout_addr1, 1'b0);
    chk("one_last", dout_last1, 1'b1);
    chk("one_busy", busy1, 1'b1);
    @(posedge clk);
    #1;
    chk("one_done", done1, 1'b1);
    chk("one_dvalid", dout_valid1, 1'b0);
    @(posedge clk);
    #1;
    chk("one_done_end", done1, 1'b0);
    chk("one_busy_end", busy1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
